// File: rtl/tlp_reg_bank.sv
// tlp_reg_bank: host register bank behind the PCIe TLP transceiver (ID, scratch, mailbox FIFO, GP regs).
// Latency: reads are combinational (0 cycles); writes, pushes and pops become visible one cycle later.
// Backpressure: cpuWrReady_out drops only for mailbox writes while the FIFO is full; optional counter via TLP_REG_BANK_COUNTER_EN.
module tlp_reg_bank #(
  parameter int          REG_ABITS  = 5,
  parameter int          FIFO_ABITS = 4,
  parameter logic [31:0] ID_VALUE   = 32'hCAFE0001
) (
  input  logic                 pcieClk_in,
  input  logic                 pcieRstN_in,
  input  logic [REG_ABITS-1:0] cpuChan_in,
  input  logic [31:0]          cpuWrData_in,
  input  logic                 cpuWrValid_in,
  output logic                 cpuWrReady_out,
  output logic [31:0]          cpuRdData_out,
  output logic                 cpuRdValid_out,
  input  logic                 cpuRdReady_in,
  output logic [31:0]          mbxData_out,
  output logic                 mbxValid_out,
  input  logic                 mbxReady_in
);

  localparam int NUM_G = (1 << REG_ABITS) - 7;
  localparam int DEPTH = 1 << FIFO_ABITS;

  localparam logic [REG_ABITS-1:0]  CH_ID      = REG_ABITS'(2);
  localparam logic [REG_ABITS-1:0]  CH_SCRATCH = REG_ABITS'(3);
  localparam logic [REG_ABITS-1:0]  CH_MBX     = REG_ABITS'(4);
  localparam logic [REG_ABITS-1:0]  CH_STATUS  = REG_ABITS'(5);
  localparam logic [REG_ABITS-1:0]  CH_CNT     = REG_ABITS'(6);
  localparam logic [REG_ABITS-1:0]  CH_G0      = REG_ABITS'(7);
  localparam logic [FIFO_ABITS:0]   DEPTH_CNT  = (FIFO_ABITS+1)'(DEPTH);

  // rstDone stays low for the reset cycles and the first cycle after release,
  // which keeps every host-visible output quiet until state is known-good.
  logic                  rstDone;
  logic [31:0]           scratchReg;
  logic [31:0]           gReg [NUM_G];
  logic [31:0]           mbxMem [DEPTH];
  logic [FIFO_ABITS-1:0] wrPtr;
  logic [FIFO_ABITS-1:0] rdPtr;
  logic [FIFO_ABITS:0]   mbxCount;

  logic                  mbxFull;
  logic                  mbxEmpty;
  logic                  wrXfer;
  logic                  mbxPush;
  logic                  mbxPop;
  logic                  isG;
  logic [REG_ABITS-1:0]  gIdx;
  logic [31:0]           rdMux;

  assign mbxFull  = (mbxCount == DEPTH_CNT);
  assign mbxEmpty = (mbxCount == '0);
  assign isG      = (cpuChan_in >= CH_G0);
  assign gIdx     = cpuChan_in - CH_G0;

  // Full is taken from the registered count, so a same-cycle pop does not reopen ready.
  assign cpuWrReady_out = rstDone && !((cpuChan_in == CH_MBX) && mbxFull);
  assign wrXfer         = cpuWrValid_in && cpuWrReady_out;
  assign mbxPush        = wrXfer && (cpuChan_in == CH_MBX);
  assign mbxValid_out   = rstDone && !mbxEmpty;
  assign mbxPop         = mbxValid_out && mbxReady_in;
  assign mbxData_out    = rstDone ? mbxMem[rdPtr] : '0;
  assign cpuRdValid_out = rstDone;
  assign cpuRdData_out  = rstDone ? rdMux : '0;

  // Track the first full cycle out of reset.
  always_ff @(posedge pcieClk_in) begin
    if (!pcieRstN_in) rstDone <= 1'b0;
    else              rstDone <= 1'b1;
  end

  // Scratch and general-purpose register writes.
  always_ff @(posedge pcieClk_in) begin
    if (!pcieRstN_in) begin
      scratchReg <= '0;
      for (int i = 0; i < NUM_G; i++) gReg[i] <= '0;
    end else if (wrXfer) begin
      if (cpuChan_in == CH_SCRATCH) scratchReg <= cpuWrData_in;
      if (isG) gReg[gIdx] <= cpuWrData_in;
    end
  end

  // Mailbox storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge pcieClk_in) begin
    if (pcieRstN_in && mbxPush) mbxMem[wrPtr] <= cpuWrData_in;
  end

  // Mailbox pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge pcieClk_in) begin
    if (!pcieRstN_in) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      mbxCount <= '0;
    end else begin
      if (mbxPush) wrPtr <= wrPtr + 1'b1;
      if (mbxPop)  rdPtr <= rdPtr + 1'b1;
      case ({mbxPush, mbxPop})
        2'b10:   mbxCount <= mbxCount + 1'b1;
        2'b01:   mbxCount <= mbxCount - 1'b1;
        default: mbxCount <= mbxCount;
      endcase
    end
  end

`ifdef TLP_REG_BANK_COUNTER_EN
  logic [31:0] cntReg;

  // Free-running cycle counter; a host write reloads it and counting resumes next cycle.
  always_ff @(posedge pcieClk_in) begin
    if (!pcieRstN_in)                             cntReg <= '0;
    else if (wrXfer && (cpuChan_in == CH_CNT))    cntReg <= cpuWrData_in;
    else                                          cntReg <= cntReg + 32'd1;
  end
`endif

  // Zero-latency read mux over registered state; channels 0/1 belong to the transceiver and read 0.
  always_comb begin
    rdMux = '0;
    case (cpuChan_in)
      CH_ID:      rdMux = ID_VALUE;
      CH_SCRATCH: rdMux = scratchReg;
      CH_MBX:     rdMux = 32'(mbxCount);
      CH_STATUS:  rdMux = {mbxFull, mbxEmpty, 30'(mbxCount)} & 32'hFFFFFFFF;
`ifdef TLP_REG_BANK_COUNTER_EN
      CH_CNT:     rdMux = cntReg;
`endif
      default: begin
        if (isG) rdMux = gReg[gIdx];
      end
    endcase
  end

  // Reads have no side effects; the read handshake is only watched for sanity.
  always @(posedge pcieClk_in) begin
    assert (!$isunknown(cpuRdReady_in));
  end

endmodule
